// File: rtl/store_unit_pkg.sv
// Shared types for the store back end: operation codes, data word and FSM state encodings.
package store_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  oper_t;

  localparam oper_t OP_NOP = 4'd0;
  localparam oper_t OP_SB  = 4'd1;
  localparam oper_t OP_SH  = 4'd2;
  localparam oper_t OP_SW  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/store_unit_if.sv
// Request handshake and byte-wide memory write port of the store unit.
interface store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  import store_unit_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  oper_t                 req_op;
  word_t                 req_base;
  word_t                 req_imm;
  word_t                 req_data;
  logic                  mem_grant;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [7:0]            mem_dout;
  logic                  done;

  // Pipeline/arbiter side.
  modport master (
    output req_valid, req_op, req_base, req_imm, req_data, mem_grant,
    input  req_ready, mem_wr, mem_a, mem_dout, done
  );

  // Store unit side.
  modport slave (
    input  req_valid, req_op, req_base, req_imm, req_data, mem_grant,
    output req_ready, mem_wr, mem_a, mem_dout, done
  );

endinterface

// File: rtl/store_unit.sv
// Executes one SB/SH/SW as a little-endian byte-serial write sequence, then pulses done.
module store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  store_unit_if.slave  bus
);
  import store_unit_pkg::*;

  state_t     state, state_nx;
  word_t      addr_q, data_q;
  logic [2:0] cnt_q;
  logic [1:0] k_q;
  word_t      eff_a;
  logic       accept, wr, last;

  function automatic logic [2:0] op_bytes(input oper_t op);
    case (op)
      OP_SB:   return 3'd1;
      OP_SH:   return 3'd2;
      OP_SW:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  assign eff_a = addr_q + {30'd0, k_q};
  assign last  = ({1'b0, k_q} == (cnt_q - 3'd1));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    wr       = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = bus.req_valid && rdy_in;
        if (accept)
          state_nx = (op_bytes(bus.req_op) == 3'd0) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        // A byte goes out only on a granted, enabled cycle; otherwise k holds.
        wr = bus.mem_grant && rdy_in;
        if (wr && last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (rdy_in) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.mem_wr    = wr;
  assign bus.mem_a     = eff_a[ADDR_WIDTH-1:0];
  assign bus.mem_dout  = data_q[{k_q, 3'b000} +: 8];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      k_q    <= '0;
    end else if (rdy_in) begin
      state <= state_nx;
      if (accept) begin
        addr_q <= bus.req_base + bus.req_imm;
        data_q <= bus.req_data;
        cnt_q  <= op_bytes(bus.req_op);
        k_q    <= '0;
      end else if (wr && !last) begin
        k_q <= k_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected writes are queued per request and checked as mem_wr fires.
module tb_store_unit;
  import store_unit_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  always #5 clk_in = ~clk_in;

  store_unit_if #(.ADDR_WIDTH(32)) bus ();

  store_unit #(.ADDR_WIDTH(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  errors  = 0;
  int  checks  = 0;
  int  wr_seen = 0;

  // grant / enable per cycle of the stall scenario, bit i = cycle i
  localparam bit [8:0] G_PAT = 9'b101111001;
  localparam bit [8:0] R_PAT = 9'b111100111;

  always @(negedge clk_in) begin : monitor
    wr_t e;
    if (bus.mem_wr === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got a=%h d=%h, required no write", bus.mem_a, bus.mem_dout);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_a !== e.a || bus.mem_dout !== e.d) begin
          errors++;
          $display("FAIL write_data: got a=%h d=%h, required a=%h d=%h", bus.mem_a, bus.mem_dout, e.a, e.d);
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input oper_t op, input word_t b, input word_t i, input word_t dt);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk_in); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_ready_timeout: req_ready=%b, required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_base  = b;
    bus.req_imm   = i;
    bus.req_data  = dt;
    @(posedge clk_in); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
  endtask

  task automatic wait_done(input int max, output int lat);
    for (lat = 0; lat < max; lat++) begin
      @(negedge clk_in);
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_in        = 1'b1;
    rdy_in        = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SW;
    bus.req_base  = 32'h1234;
    bus.req_imm   = 32'h0;
    bus.req_data  = 32'hFFFF_FFFF;
    bus.mem_grant = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.req_ready); end
    checks++;
    if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b, required 0", bus.mem_wr); end
    checks++;
    if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h, required 0", bus.mem_a); end
    checks++;
    if (bus.mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout: got %h, required 0", bus.mem_dout); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
  endtask

  task automatic test_sw();
    int lat;
    int w0 = wr_seen;
    bus.mem_grant = 1'b1;
    push(32'h1004, 8'hD4);
    push(32'h1005, 8'hC3);
    push(32'h1006, 8'hB2);
    push(32'h1007, 8'hA1);
    send(OP_SW, 32'h1000, 32'h4, 32'hA1B2C3D4);
    wait_done(20, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL sw_latency: got %0d, required 4", lat); end
    checks++;
    if (wr_seen - w0 != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL sw_write_count: got %0d, required 4", wr_seen - w0);
    end
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL sw_ready_in_done: got %b, required 0", bus.req_ready); end
    @(posedge clk_in); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL sw_return_idle: got ready=%b done=%b, required ready=1 done=0", bus.req_ready, bus.done);
    end
  endtask

  task automatic test_sh();
    int lat;
    int w0 = wr_seen;
    bus.mem_grant = 1'b1;
    push(32'h2000, 8'hEF);
    push(32'h2001, 8'hBE);
    send(OP_SH, 32'h2001, 32'hFFFF_FFFF, 32'h0000_BEEF);
    wait_done(20, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL sh_latency: got %0d, required 2", lat); end
    repeat (3) @(negedge clk_in);
    checks++;
    if (wr_seen - w0 != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL sh_write_count: got %0d, required 2", wr_seen - w0);
    end
  endtask

  task automatic test_sb_wrap();
    int lat;
    int w0 = wr_seen;
    bus.mem_grant = 1'b1;
    push(32'h0000_0000, 8'h55);
    send(OP_SB, 32'hFFFF_FFFF, 32'h1, 32'h0000_0055);
    wait_done(20, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL sb_latency: got %0d, required 1", lat); end
    checks++;
    if (wr_seen - w0 != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL sb_write_count: got %0d, required 1", wr_seen - w0);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_stall();
    int lat;
    int w0 = wr_seen;
    bus.mem_grant = 1'b1;
    push(32'h4000, 8'hEF);
    push(32'h4001, 8'hBE);
    push(32'h4002, 8'hAD);
    push(32'h4003, 8'hDE);
    send(OP_SW, 32'h4000, 32'h0, 32'hDEADBEEF);
    for (int i = 0; i < 9; i++) begin
      bus.mem_grant = G_PAT[i];
      rdy_in        = R_PAT[i];
      @(negedge clk_in);
      if (!R_PAT[i]) begin
        checks++;
        if ({bus.mem_wr, bus.req_ready, bus.done, bus.mem_a, bus.mem_dout} !== {3'b000, 32'h4001, 8'hBE}) begin
          errors++;
          $display("FAIL stall_frozen: got wr=%b rdy=%b done=%b a=%h d=%h, required wr=0 rdy=0 done=0 a=00004001 d=be",
                   bus.mem_wr, bus.req_ready, bus.done, bus.mem_a, bus.mem_dout);
        end
      end
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL stall_early_done: cycle %0d got 1, required 0", i); end
      @(posedge clk_in); #1;
    end
    bus.mem_grant = 1'b1;
    rdy_in        = 1'b1;
    wait_done(10, lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL stall_done_timing: got %0d, required 0", lat); end
    checks++;
    if (wr_seen - w0 != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_write_count: got %0d, required 4", wr_seen - w0);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset_abort();
    int w0 = wr_seen;
    bus.mem_grant = 1'b1;
    push(32'h3000, 8'h44);
    push(32'h3001, 8'h33);
    send(OP_SW, 32'h3000, 32'h0, 32'h11223344);
    repeat (2) begin @(posedge clk_in); #1; end
    rst_in        = 1'b1;
    bus.mem_grant = 1'b0;
    @(posedge clk_in); #1;
    rst_in        = 1'b0;
    bus.mem_grant = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({bus.mem_wr, bus.done, bus.req_ready} !== 3'b001) begin
      errors++; $display("FAIL abort_state: got wr=%b done=%b rdy=%b, required wr=0 done=0 rdy=1", bus.mem_wr, bus.done, bus.req_ready);
    end
    checks++;
    if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL abort_mem_a: got %h, required 0", bus.mem_a); end
    repeat (5) @(negedge clk_in);
    checks++;
    if (wr_seen - w0 != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_write_count: got %0d, required 2", wr_seen - w0);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_nop();
    int w0 = wr_seen;
    bus.mem_grant = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_NOP;
    bus.req_base  = 32'h5000;
    bus.req_imm   = 32'h0;
    bus.req_data  = 32'h0;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    checks++;
    if (bus.done !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL nop_done: got done=%b rdy=%b, required done=1 rdy=0", bus.done, bus.req_ready);
    end
    @(posedge clk_in); #1;
    @(negedge clk_in);
    checks++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL nop_no_reaccept: got done=%b rdy=%b, required done=0 rdy=1", bus.done, bus.req_ready);
    end
    @(posedge clk_in); #1;
    bus.req_valid = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL nop_reaccept: got done=%b, required 1", bus.done); end
    @(posedge clk_in); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b1 || wr_seen != w0) begin
      errors++; $display("FAIL nop_final: got done=%b rdy=%b writes=%0d, required done=0 rdy=1 writes=0",
                         bus.done, bus.req_ready, wr_seen - w0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    bus.req_base  = '0;
    bus.req_imm   = '0;
    bus.req_data  = '0;
    bus.mem_grant = 1'b0;
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    test_reset();
    test_sw();
    test_sh();
    test_sb_wrap();
    test_stall();
    test_reset_abort();
    test_nop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
